exe_muldiv_ctrl: RTL and testbench
==================================

Name: exe_muldiv_ctrl

Overview:
- Multi-cycle multiply/divide sequencer for the EXE stage of the 5-stage MIPS pipeline. It sits beside the single-cycle ALU.
- Owns the architectural HI/LO registers and executes MULT/MULTU/DIV/DIVU iteratively (shift-add, restoring divide). Also executes MTHI/MTLO.
- Drives a stall request so the hazard logic freezes IF/ID/EXE while a HI/LO consumer or a new mul/div meets a busy unit.

Parameters:
- DATA_W, 32, operand/HI/LO width; iteration count equals DATA_W.

Ports:
- clk  input  1  pipeline clock
- rst  input  1  one clock; reset is synchronous and active-high
- start  input  1  EXE holds a muldiv-class instruction (op valid)
- md_op  input  3  operation code (package constants)
- src_a  input  DATA_W  rs operand (dividend / multiplicand / MTHI-MTLO data)
- src_b  input  DATA_W  rt operand (divisor / multiplier)
- rd_hilo  input  1  EXE holds MFHI/MFLO
- flush  input  1  squash the in-flight operation (branch/exception)
- stall_o  output  1  freeze pipeline at EXE
- busy  output  1  sequencer not IDLE
- done  output  1  one-cycle pulse, HI/LO written at end of this cycle
- hi_o  output  DATA_W  registered HI
- lo_o  output  DATA_W  registered LO

Behaviour:
- Reset (sync, rst=1 at posedge): state=IDLE, HI=LO=0, busy=0, done=0. Reset mid-operation discards the operation.
- States:
  - IDLE -> CALC: start with a mul/div op and no flush.
  - IDLE -> FIN: DIV/DIVU with src_b==0.
  - CALC runs exactly DATA_W cycles (counter DATA_W-1 down to 0), then -> FIN.
  - FIN -> IDLE: unconditional.
- Latency: start sampled at edge t; CALC covers t+1..t+DATA_W; FIN at t+DATA_W+1 with done=1. HI/LO update at the end of FIN. Divide-by-zero: FIN at t+1.
- Operands are latched at acceptance; later input changes have no effect.
- Signed ops:
  - Operate on magnitudes; fix signs in FIN.
  - Product sign = a^b. Quotient sign = a^b. Remainder takes the dividend's sign.
  - Magnitude of -2^DATA_W-1 is representable unsigned.
- Results: MULT(U) gives {HI,LO} = 2*DATA_W-bit product. DIV(U) gives LO=quotient, HI=remainder.
- Divide by zero: LO=all ones, HI=src_a.
- DIV 0x80000000 / -1: LO=0x80000000, HI=0.
- MTHI/MTLO: accepted only in IDLE. Write at the end of the start cycle; no busy, no done.
- busy = (state != IDLE).
- stall_o = busy & (start | rd_hilo). Combinational; must not depend on stall_o.
- start while busy: ignored; the instruction is held by stall and re-presented. It is accepted in the first IDLE cycle, one cycle after FIN.
- rd_hilo in IDLE: no stall; hi_o/lo_o show committed values.
- flush:
  - In CALC or FIN: state -> IDLE next edge, HI/LO unchanged, no done.
  - In IDLE with start: start is dropped, including MTHI/MTLO.
  - flush has priority over done.
- Undefined md_op codes with start: no state change, no stall.

Decomposition:
- Shared package exe_md_pkg:
  - md_op encodings: MD_MULT=0, MD_MULTU=1, MD_DIV=2, MD_DIVU=3, MD_MTHI=4, MD_MTLO=5.
  - State encoding: IDLE, CALC, FIN.
  - Constant DATA_W=32.
- One sub-module is natural: md_iter_core, the shift-add/restoring-subtract datapath with a 2*DATA_W accumulator.
- exe_muldiv_ctrl keeps the FSM, counter, sign fixup, HI/LO and stall logic.

Test Plan:
- MULT src_a=0xFFFFFFFD (-3), src_b=5 at t -> done at t+33, then HI=0xFFFFFFFF, LO=0xFFFFFFF1; busy t+1..t+33.
- MULTU 0xFFFFFFFF * 2 -> HI=0x00000001, LO=0xFFFFFFFE; then DIV 0xFFFFFFF9 (-7) / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU src_a=0x1234, src_b=0 -> done at t+1, LO=0xFFFFFFFF, HI=0x1234; DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- MULT in flight, rd_hilo=1 at t+5 -> stall_o=1 through FIN; stall_o=0 in the first IDLE cycle; hi_o/lo_o hold the new product.
- MTLO 0xA5A5A5A5 presented while busy -> stalled, accepted the cycle after FIN, LO=0xA5A5A5A5; MTHI in IDLE -> HI written next edge, stall_o=0.
- flush at CALC cycle 10 -> busy=0 next edge, HI/LO unchanged, no done. rst=1 mid-CALC -> IDLE, HI=LO=0 next edge.

Source files
------------

// File: rtl/exe_md_pkg.sv
// Shared types and constants for the EXE-stage multiply/divide sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package exe_md_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIN  = 2'd2
    } md_state_e;

    // Iterative ops; MTHI/MTLO and undefined codes are excluded.
    function automatic logic is_iter_op(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_iter_core.sv
// Shift-add multiply / restoring divide datapath on unsigned magnitudes.
// Latency: one iteration per step cycle; W steps give the full result.
// Backpressure: none; advances only when step is asserted by the sequencer.
//
// Ports: clk, rst (sync high); load latches mag_a/mag_b and clears the upper
// accumulator half; step performs one iteration; is_div selects divide;
// acc_o = {HI,LO} magnitude ({remainder, quotient} for divide).
module md_iter_core #(
    parameter int W = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load,
    input  logic           step,
    input  logic           is_div,
    input  logic [W-1:0]   mag_a,
    input  logic [W-1:0]   mag_b,
    output logic [2*W-1:0] acc_o
);

    logic [W-1:0]   b_q;
    logic [2*W-1:0] acc_q;
    logic [W:0]     add_sum;
    logic [W:0]     sub_diff;

    always_comb begin
        // Multiply: add multiplicand into the upper half when the LSB is set.
        add_sum  = {1'b0, acc_q[2*W-1:W]} + {1'b0, (acc_q[0] ? b_q : {W{1'b0}})};
        // Divide: trial-subtract divisor from the remainder shifted left by one.
        sub_diff = acc_q[2*W-1:W-1] - {1'b0, b_q};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            b_q   <= '0;
        end else if (load) begin
            acc_q <= {{W{1'b0}}, mag_a};
            b_q   <= mag_b;
        end else if (step) begin
            if (is_div) begin
                if (!sub_diff[W])
                    acc_q <= {sub_diff[W-1:0], acc_q[W-2:0], 1'b1};
                else
                    acc_q <= {acc_q[2*W-2:0], 1'b0};
            end else begin
                acc_q <= {add_sum, acc_q[W-1:1]};
            end
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/exe_muldiv_ctrl.sv
// MIPS EXE-stage mul/div sequencer owning HI/LO; MTHI/MTLO write directly.
// Latency: MULT/DIV done DATA_W+1 cycles after acceptance, divide-by-zero after 1.
// Backpressure: stall_o while busy and EXE holds a mul/div or MFHI/MFLO.
//
// Ports: clk, rst (sync high); start/md_op/src_a/src_b present an op;
// rd_hilo marks MFHI/MFLO in EXE; flush squashes; stall_o, busy, done;
// hi_o/lo_o are the registered HI/LO.
module exe_muldiv_ctrl #(
    parameter int DATA_W = exe_md_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2:0]        md_op,
    input  logic [DATA_W-1:0] src_a,
    input  logic [DATA_W-1:0] src_b,
    input  logic              rd_hilo,
    input  logic              flush,
    output logic              stall_o,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);
    import exe_md_pkg::*;

    localparam int CNT_W = $clog2(DATA_W);

    md_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic              div_q, neg_res_q, neg_rem_q, dz_q;
    logic [DATA_W-1:0] a_q, hi_q, lo_q;

    logic              accept, div_op, signed_op, div_zero, fin_commit, core_step;
    logic [DATA_W-1:0] mag_a, mag_b;
    logic [2*DATA_W-1:0] acc, prod;
    logic [DATA_W-1:0] quo, rem;

    always_comb begin
        div_op    = (md_op == MD_DIV) || (md_op == MD_DIVU);
        signed_op = (md_op == MD_MULT) || (md_op == MD_DIV);
        div_zero  = div_op && (src_b == '0);
        accept    = (state_q == ST_IDLE) && start && !flush && is_iter_op(md_op);
        // Two's-complement negate of the most negative value yields its
        // correct unsigned magnitude, so no special case is needed.
        mag_a     = (signed_op && src_a[DATA_W-1]) ? (~src_a + 1'b1) : src_a;
        mag_b     = (signed_op && src_b[DATA_W-1]) ? (~src_b + 1'b1) : src_b;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = div_zero ? ST_FIN : ST_CALC;
            ST_CALC: begin
                if (flush)              state_d = ST_IDLE;
                else if (cnt_q == '0)   state_d = ST_FIN;
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy       = (state_q != ST_IDLE);
        fin_commit = (state_q == ST_FIN) && !flush;
        done       = fin_commit && !rst;
        stall_o    = busy && (start || rd_hilo);
        core_step  = (state_q == ST_CALC) && !flush;
    end

    md_iter_core #(.W(DATA_W)) u_core (
        .clk    (clk),
        .rst    (rst),
        .load   (accept),
        .step   (core_step),
        .is_div (div_q),
        .mag_a  (mag_a),
        .mag_b  (mag_b),
        .acc_o  (acc)
    );

    // Sign fixup applied in FIN on the magnitude result.
    always_comb begin
        prod = neg_res_q ? (~acc + 1'b1) : acc;
        quo  = neg_res_q ? (~acc[DATA_W-1:0] + 1'b1) : acc[DATA_W-1:0];
        rem  = neg_rem_q ? (~acc[2*DATA_W-1:DATA_W] + 1'b1) : acc[2*DATA_W-1:DATA_W];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            div_q     <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            a_q       <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            if (accept) begin
                cnt_q     <= CNT_W'(DATA_W - 1);
                div_q     <= div_op;
                neg_res_q <= signed_op && (src_a[DATA_W-1] ^ src_b[DATA_W-1]);
                neg_rem_q <= signed_op && src_a[DATA_W-1];
                dz_q      <= div_zero;
                a_q       <= src_a;
            end else if (state_q == ST_CALC) begin
                cnt_q <= cnt_q - 1'b1;
            end

            if (fin_commit) begin
                if (dz_q) begin
                    lo_q <= '1;
                    hi_q <= a_q;
                end else if (div_q) begin
                    lo_q <= quo;
                    hi_q <= rem;
                end else begin
                    {hi_q, lo_q} <= prod;
                end
            end else if ((state_q == ST_IDLE) && start && !flush) begin
                if (md_op == MD_MTHI) hi_q <= src_a;
                if (md_op == MD_MTLO) lo_q <= src_a;
            end
        end
    end

    assign hi_o = hi_q;
    assign lo_o = lo_q;

endmodule

// File: tb/tb_exe_muldiv_ctrl.sv
module tb_exe_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] src_a, src_b;
    logic        rd_hilo, flush;
    logic        stall_o, busy, done;
    logic [31:0] hi_o, lo_o;

    int n_vec = 0;
    int n_bad = 0;

    exe_muldiv_ctrl #(.DATA_W(32)) dut (
        .clk(clk), .rst(rst), .start(start), .md_op(md_op),
        .src_a(src_a), .src_b(src_b), .rd_hilo(rd_hilo), .flush(flush),
        .stall_o(stall_o), .busy(busy), .done(done), .hi_o(hi_o), .lo_o(lo_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } vec_t;

    vec_t tbl [11];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int idx);
        int cyc;
        cyc = 0;
        md_op = tbl[idx].op; src_a = tbl[idx].a; src_b = tbl[idx].b; start = 1'b1;
        #1;
        chk($sformatf("v%0d idle_busy", idx), 32'(busy), 32'd0);
        tick();
        start = 1'b0;
        src_a = ~tbl[idx].a;       // operands must already be latched
        src_b = ~tbl[idx].b;
        chk($sformatf("v%0d busy_after_accept", idx), 32'(busy), 32'd1);
        for (int i = 1; i <= 40; i++) begin
            if (done) begin
                cyc = i;
                break;
            end
            tick();
        end
        chk($sformatf("v%0d latency", idx), 32'(cyc), 32'(tbl[idx].lat));
        tick();
        chk($sformatf("v%0d hi", idx), hi_o, tbl[idx].hi);
        chk($sformatf("v%0d lo", idx), lo_o, tbl[idx].lo);
        chk($sformatf("v%0d busy_end", idx), 32'(busy), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic ok;
        logic seen;
        //            op    a             b             hi            lo            lat
        tbl[0]  = '{3'd0, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 33};
        tbl[1]  = '{3'd1, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, 33};
        tbl[2]  = '{3'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 33};
        tbl[3]  = '{3'd3, 32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF, 1};
        tbl[4]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33};
        tbl[5]  = '{3'd3, 32'd100,      32'd7,        32'd2,        32'd14,       33};
        tbl[6]  = '{3'd0, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFF2, 33};
        tbl[7]  = '{3'd2, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 33};
        tbl[8]  = '{3'd1, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 33};
        tbl[9]  = '{3'd2, 32'hFFFFFFF8, 32'h00000000, 32'hFFFFFFF8, 32'hFFFFFFFF, 1};
        tbl[10] = '{3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 33};

        rst = 1'b1; start = 1'b0; md_op = 3'd0; src_a = '0; src_b = '0;
        rd_hilo = 1'b0; flush = 1'b0;
        tick(); tick();
        chk("rst_hi", hi_o, 32'd0);
        chk("rst_lo", lo_o, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        rst = 1'b0;
        tick();

        for (int v = 0; v < 11; v++) run_vec(v);

        // MFHI/MFLO arriving mid-MULT stalls through FIN, released in IDLE.
        md_op = 3'd0; src_a = 32'd6; src_b = 32'd7; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        rd_hilo = 1'b1;
        #1;
        ok = 1'b1;
        for (int i = 0; i < 40 && busy; i++) begin
            if (!stall_o) ok = 1'b0;
            tick();
        end
        chk("rdhilo_stall_while_busy", 32'(ok), 32'd1);
        chk("rdhilo_busy_cleared", 32'(busy), 32'd0);
        chk("rdhilo_stall_idle", 32'(stall_o), 32'd0);
        chk("rdhilo_lo", lo_o, 32'd42);
        chk("rdhilo_hi", hi_o, 32'd0);
        rd_hilo = 1'b0;

        // MTLO held by stall during MULTU, accepted the cycle after FIN.
        md_op = 3'd1; src_a = 32'd3; src_b = 32'd3; start = 1'b1;
        tick();
        md_op = 3'd5; src_a = 32'hA5A5A5A5;
        #1;
        ok = 1'b1;
        for (int i = 0; i < 40 && busy; i++) begin
            if (!stall_o) ok = 1'b0;
            tick();
        end
        chk("mtlo_stall_while_busy", 32'(ok), 32'd1);
        chk("mtlo_stall_idle", 32'(stall_o), 32'd0);
        chk("mtlo_mul_result", lo_o, 32'd9);
        tick();
        start = 1'b0;
        chk("mtlo_lo", lo_o, 32'hA5A5A5A5);
        chk("mtlo_hi", hi_o, 32'd0);
        chk("mtlo_busy", 32'(busy), 32'd0);

        // MTHI in IDLE
        md_op = 3'd4; src_a = 32'h00005A5A; start = 1'b1;
        #1;
        chk("mthi_stall", 32'(stall_o), 32'd0);
        tick();
        start = 1'b0;
        chk("mthi_hi", hi_o, 32'h00005A5A);
        chk("mthi_busy", 32'(busy), 32'd0);
        chk("mthi_done", 32'(done), 32'd0);

        // flush at CALC cycle 10
        md_op = 3'd0; src_a = 32'd2; src_b = 32'd3; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        flush = 1'b1;
        #1;
        chk("flush_done_now", 32'(done), 32'd0);
        tick();
        flush = 1'b0;
        chk("flush_busy", 32'(busy), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done) seen = 1'b1;
            tick();
        end
        chk("flush_no_done", 32'(seen), 32'd0);
        chk("flush_hi", hi_o, 32'h00005A5A);
        chk("flush_lo", lo_o, 32'hA5A5A5A5);

        // flush in IDLE drops start, including MTLO
        md_op = 3'd5; src_a = 32'h11111111; start = 1'b1; flush = 1'b1;
        tick();
        chk("idleflush_lo", lo_o, 32'hA5A5A5A5);
        md_op = 3'd0;
        tick();
        chk("idleflush_busy", 32'(busy), 32'd0);
        start = 1'b0; flush = 1'b0;

        // undefined opcode
        md_op = 3'd6; src_a = 32'h1; src_b = 32'h1; start = 1'b1;
        #1;
        chk("undef_stall", 32'(stall_o), 32'd0);
        tick();
        chk("undef_busy", 32'(busy), 32'd0);
        chk("undef_hi", hi_o, 32'h00005A5A);
        start = 1'b0;

        // reset mid-CALC
        md_op = 3'd0; src_a = 32'd2; src_b = 32'd3; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("midrst_busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_hi", hi_o, 32'd0);
        chk("midrst_lo", lo_o, 32'd0);
        chk("midrst_done", 32'(done), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
